// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Groups the handshake and strobe signals between the control sequencer
//   and the DataPath it drives.
//   Signals:
//     run, mem_ready, ir      : status into the sequencer
//     PCout..LOin             : single-bit datapath strobes from the sequencer
//     reg_in / reg_out        : one-hot register-file load / drive enables
//     opcode                  : ALU operation select
//     halted / illegal        : terminal-state indicators
//   Modports:
//     master : sequencer side (drives the strobes)
//     slave  : datapath / environment side (drives run, mem_ready, ir)
interface control_sequencer_if #(
    parameter int unsigned NUM_REGS = 16
);
    logic                run;
    logic                mem_ready;
    logic [31:0]         ir;

    logic                PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin;
    logic                ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic [4:0]          opcode;
    logic                halted;
    logic                illegal;

    modport master (
        input  run, mem_ready, ir,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin,
        output ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin,
        output reg_in, reg_out, opcode, halted, illegal
    );

    modport slave (
        output run, mem_ready, ir,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin,
        input  ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin,
        input  reg_in, reg_out, opcode, halted, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore control unit sequencing DataPath through fetch (T0-T2) and
//   execute (T3-T6) for register-register ALU and MUL/DIV instructions.
//   Register-file enables are decoded from IR fields into one-hot vectors.
//   Ports:
//     clock : system clock, rising edge
//     clear : asynchronous active-high reset (state IDLE, all outputs 0)
//     step  : single-step gate, present only with SINGLE_STEP_EN defined
//     bus   : control_sequencer_if.master (run, mem_ready, ir in; strobes out)
//   Build option:
//     SINGLE_STEP_EN : adds `step`; each fetch waits for step=1, one step
//                      pulse runs exactly one instruction.
module control_sequencer #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [4:0]  OP_MUL   = 5'b01111,
    parameter logic [4:0]  OP_DIV   = 5'b10000,
    parameter logic [4:0]  OP_HALT  = 5'b11011
) (
    input  logic clock,
    input  logic clear,
`ifdef SINGLE_STEP_EN
    input  logic step,
`endif
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
`ifdef SINGLE_STEP_EN
        S_WAIT,
`endif
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6,
        S_HALT, S_ILLEGAL
    } state_t;

    // Opcodes at or above OP_MUL+2 (other than HALT) are undefined.
    localparam logic [5:0] OP_FIRST_BAD = {1'b0, OP_MUL} + 6'd2;
    localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    state_t state, state_nx;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_wide, is_halt, is_bad;
    logic       launch;
    state_t     rest_state;
    logic       unused_ir;

    assign op        = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    assign is_wide = (op == OP_MUL) || (op == OP_DIV);
    assign is_halt = (op == OP_HALT);
    assign is_bad  = ({1'b0, op} >= OP_FIRST_BAD) && !is_halt;

    // Fetch-entry gate shared by IDLE, T5 (ALU), T6 and WAIT: launch says
    // whether the next instruction may start, rest_state is where to park.
`ifdef SINGLE_STEP_EN
    assign launch     = bus.run && step;
    assign rest_state = bus.run ? S_WAIT : S_IDLE;
`else
    assign launch     = bus.run;
    assign rest_state = S_IDLE;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Read     = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.ZLowIn   = 1'b0;
        bus.ZHighIn  = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.reg_in   = '0;
        bus.reg_out  = '0;
        bus.opcode   = '0;
        bus.halted   = 1'b0;
        bus.illegal  = 1'b0;

        case (state)
            S_IDLE: state_nx = launch ? S_T0 : rest_state;
`ifdef SINGLE_STEP_EN
            S_WAIT: state_nx = launch ? S_T0 : rest_state;
`endif
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.PCin  = 1'b1;
                state_nx  = S_T1;
            end
            S_T1: begin
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                if (bus.mem_ready) state_nx = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_nx   = S_T3;
            end
            S_T3: begin
                bus.reg_out = ONE_HOT0 << rb;
                bus.Yin     = 1'b1;
                if (is_bad)       state_nx = S_ILLEGAL;
                else if (is_halt) state_nx = S_HALT;
                else              state_nx = S_T4;
            end
            S_T4: begin
                bus.reg_out = ONE_HOT0 << rc;
                bus.opcode  = op;
                bus.ZLowIn  = 1'b1;
                bus.ZHighIn = is_wide;
                state_nx    = S_T5;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_wide) begin
                    bus.LOin = 1'b1;
                    state_nx = S_T6;
                end else begin
                    bus.reg_in = ONE_HOT0 << ra;
                    state_nx   = launch ? S_T0 : rest_state;
                end
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                state_nx     = launch ? S_T0 : rest_state;
            end
            S_HALT:    bus.halted  = 1'b1;
            S_ILLEGAL: bus.illegal = 1'b1;
            default:   state_nx    = S_IDLE;
        endcase
    end

endmodule
